node_translate: RTL
===================

# node_translate

Rigid-body translator for the soft-body node array. Takes the current center of mass (as produced by `center_of_mass`) and a target position, then walks the node memory once, read-modify-writing each node so the body's center of mass moves to the target. It is the writer-side counterpart to `center_of_mass`, which reads nodes and reduces them to a centroid. It sits between the physics step and the node RAM and is used for respawn/recenter operations.

## Interface
- `POSITION_SIZE`, 8, signed width of one coordinate.
- `NUM_NODES`, 4, number of nodes in memory, at addresses 0..NUM_NODES-1.
- `ADDR_WIDTH`, `$clog2(NUM_NODES)` (min 1), node memory address width.

Ports:
- `clk_in`  input  1  system clock, rising-edge.
- `rst_in`  input  1  asynchronous, active-low reset.
- `valid_in`  input  1  start pulse; samples `com_*_in` and `target_*_in`.
- `com_x_in`, `com_y_in`  input  POSITION_SIZE  signed current center of mass.
- `target_x_in`, `target_y_in`  input  POSITION_SIZE  signed desired center of mass.
- `mem_addr_out`  output  ADDR_WIDTH  node address.
- `mem_rd_out`  output  1  read strobe; data is returned exactly 1 cycle later.
- `mem_rdata_in`  input  2*POSITION_SIZE  node word: x at [2P-1:P], y at [P-1:0].
- `mem_we_out`  output  1  write strobe.
- `mem_wdata_out`  output  2*POSITION_SIZE  node word, same packing.
- `busy_out`  output  1  high in every state except IDLE.
- `valid_out`  output  1  single-cycle pulse when all nodes are written.

## Operation
- FSM states are IDLE, READ, WAIT, WRITE, DONE.
- IDLE: when `valid_in`=1, latch `dx = target_x_in - com_x_in` and `dy = target_y_in - com_y_in`. Both are computed sign-extended to POSITION_SIZE+1 bits, so the subtraction never overflows. Set idx=0 and go to READ. `valid_in` is ignored in every other state; there is no queueing.
- READ: `mem_addr_out`=idx, `mem_rd_out`=1. Go to WAIT.
- WAIT: `mem_rdata_in` is valid. Compute `x' = x + dx` and `y' = y + dy` at POSITION_SIZE+2 bits, reduce each to POSITION_SIZE bits per Configuration, and register the result into `mem_wdata_out`. Go to WRITE.
- WRITE: `mem_addr_out`=idx, `mem_we_out`=1. If idx==NUM_NODES-1, go to DONE; otherwise idx++ and go to READ.
- DONE: `valid_out`=1 for this cycle only. Go to IDLE.
- `mem_rd_out` and `mem_we_out` are never high in the same cycle. Each is high only in its own state.
- `dx`=`dy`=0 still performs the full pass and rewrites every node with its unchanged value.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from any input to any output.
- Reset values: state=IDLE, idx=0, `mem_addr_out`=0, `mem_rd_out`=0, `mem_we_out`=0, `mem_wdata_out`=0, `busy_out`=0, `valid_out`=0.
- Latency: if `valid_in` is sampled at edge 0, READ begins at edge 1. Each node takes 3 cycles. `valid_out` is high in cycle 3*NUM_NODES+1 after the start edge; this is 13 for NUM_NODES=4.
- `busy_out` rises the cycle after the start edge and falls when the FSM returns to IDLE, one cycle after the `valid_out` pulse.
- A new `valid_in` is accepted in the first IDLE cycle after DONE, so back-to-back throughput is one translation per 3*NUM_NODES+2 cycles.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous). No further writes occur. Nodes already written keep their new values and the remaining nodes are untouched. No `valid_out` is generated.

## Configuration
- `NODE_TRANSLATE_SAT_EN` defined: each result clamps to [-2^(P-1), 2^(P-1)-1], i.e. [-128, 127] for P=8.
- Not defined: each result wraps, taking the low POSITION_SIZE bits of the sum two's-complement.
- The delta computation is identical in both builds.

## Test plan
- Basic pass: memory holds (10,20), (-5,3), (0,0), (100,-100); com=(0,0); target=(5,-3). Required memory afterwards: (15,17), (0,0), (5,-3), (105,-103). `valid_out` pulses exactly 13 cycles after `valid_in`.
- Saturation: node0=(120,-126), com=(0,0), target=(20,-10). With `NODE_TRANSLATE_SAT_EN`, node0 becomes (127,-128). Without it, node0 becomes (-116,120).
- Wide delta: com=(-128,-128), target=(127,127), so dx=dy=255. With SAT, node (0,0) becomes (127,127) and node (-128,-128) becomes (127,127).
- Busy ignore: pulse `valid_in` again with different target 5 cycles after the first start. Required: only the first delta is applied, there is a single `valid_out`, and write addresses are 0,1,2,3 in order.
- Reset mid-pass: assert `rst_in`=0 in the cycle after node 1's WRITE. Required: all outputs drop to 0 at once, nodes 0–1 are updated, nodes 2–3 keep their original values, and no `valid_out` occurs.
- Strobe protocol: across a full pass, `mem_rd_out` and `mem_we_out` are never both high, there are exactly NUM_NODES cycles of each, and each read's address equals the address of the following write.

Source files
------------

// File: rtl/node_translate.sv
// Rigid-body translator: one read-modify-write pass over the node RAM adding (target - com).
// Build option NODE_TRANSLATE_SAT_EN: clamp results to the coordinate range instead of wrapping.
module node_translate #(
  parameter int POSITION_SIZE = 8,
  parameter int NUM_NODES     = 4,
  parameter int ADDR_WIDTH    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       valid_in,
  input  logic [POSITION_SIZE-1:0]   com_x_in,
  input  logic [POSITION_SIZE-1:0]   com_y_in,
  input  logic [POSITION_SIZE-1:0]   target_x_in,
  input  logic [POSITION_SIZE-1:0]   target_y_in,
  output logic [ADDR_WIDTH-1:0]      mem_addr_out,
  output logic                       mem_rd_out,
  input  logic [2*POSITION_SIZE-1:0] mem_rdata_in,
  output logic                       mem_we_out,
  output logic [2*POSITION_SIZE-1:0] mem_wdata_out,
  output logic                       busy_out,
  output logic                       valid_out
);

  localparam int DW = POSITION_SIZE + 1;
  localparam int SW = POSITION_SIZE + 2;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t                        state_q, state_d;
  logic [ADDR_WIDTH-1:0]         idx_q;
  logic signed [DW-1:0]          dx_p0, dy_p0;
  logic signed [POSITION_SIZE-1:0] rd_x_p0, rd_y_p0;
  logic signed [SW-1:0]          sum_x_p0, sum_y_p0;
  logic [2*POSITION_SIZE-1:0]    wdata_p1;
  logic                          last_node;

`ifdef NODE_TRANSLATE_SAT_EN
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2**(POSITION_SIZE-1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = SW'(-(2**(POSITION_SIZE-1)));

  function automatic logic signed [POSITION_SIZE-1:0] reduce(input logic signed [SW-1:0] s);
    if (s > SAT_MAX)      return SAT_MAX[POSITION_SIZE-1:0];
    else if (s < SAT_MIN) return SAT_MIN[POSITION_SIZE-1:0];
    else                  return s[POSITION_SIZE-1:0];
  endfunction
`else
  function automatic logic signed [POSITION_SIZE-1:0] reduce(input logic signed [SW-1:0] s);
    return s[POSITION_SIZE-1:0];
  endfunction
`endif

  assign last_node = (idx_q == ADDR_WIDTH'(NUM_NODES - 1));

  // Stage p0: delta capture at start, node sum while the read data is on the bus
  always_ff @(posedge clk_in) begin
    if (state_q == IDLE && valid_in) begin
      dx_p0 <= {target_x_in[POSITION_SIZE-1], target_x_in} - {com_x_in[POSITION_SIZE-1], com_x_in};
      dy_p0 <= {target_y_in[POSITION_SIZE-1], target_y_in} - {com_y_in[POSITION_SIZE-1], com_y_in};
    end
  end

  assign rd_x_p0  = mem_rdata_in[2*POSITION_SIZE-1:POSITION_SIZE];
  assign rd_y_p0  = mem_rdata_in[POSITION_SIZE-1:0];
  assign sum_x_p0 = {{2{rd_x_p0[POSITION_SIZE-1]}}, rd_x_p0} + {dx_p0[DW-1], dx_p0};
  assign sum_y_p0 = {{2{rd_y_p0[POSITION_SIZE-1]}}, rd_y_p0} + {dy_p0[DW-1], dy_p0};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_in) state_d = READ;
      READ:    state_d = WAIT;
      WAIT:    state_d = WRITE;
      WRITE:   state_d = last_node ? DONE : READ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: registered write word and control state
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      wdata_p1 <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && valid_in)
        idx_q <= '0;
      else if (state_q == WRITE && !last_node)
        idx_q <= idx_q + ADDR_WIDTH'(1);
      if (state_q == WAIT)
        wdata_p1 <= {reduce(sum_x_p0), reduce(sum_y_p0)};
    end
  end

  assign mem_addr_out  = idx_q;
  assign mem_rd_out    = (state_q == READ);
  assign mem_we_out    = (state_q == WRITE);
  assign mem_wdata_out = wdata_p1;
  assign busy_out      = (state_q != IDLE);
  assign valid_out     = (state_q == DONE);

endmodule
